// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush sequencer.
// Holds the MUL/DIV FSM encoding, the x0 register index and counter saturation.
package pipe_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  // Saturating increment of a w-bit value carried in 64 bits (w <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] mask;
    if (w >= 64) mask = '1;
    else         mask = (64'd1 << w) - 64'd1;
    return (v >= mask) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the sequencer (slave).
// Carries ID/EX hazard sources in one direction and register enables, flushes, MUL/DIV controls and counters in the other.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       IF_ID_rs1;
  logic [4:0]       IF_ID_rs2;
  logic             IF_ID_use_rs1;
  logic             IF_ID_use_rs2;
  logic             ID_EX_MemRead;
  logic [4:0]       ID_EX_rd;
  logic             ex_branch_taken;
  logic             ex_md_op;
  logic             md_done;

  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             md_start;
  logic             md_abort;
  logic             md_result_sel;
  logic             md_error;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output IF_ID_rs1, IF_ID_rs2, IF_ID_use_rs1, IF_ID_use_rs2,
           ID_EX_MemRead, ID_EX_rd, ex_branch_taken, ex_md_op, md_done,
    input  pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_flush,
           md_start, md_abort, md_result_sel, md_error, stall_cycles, flush_events
  );

  modport slave (
    input  IF_ID_rs1, IF_ID_rs2, IF_ID_use_rs1, IF_ID_use_rs2,
           ID_EX_MemRead, ID_EX_rd, ex_branch_taken, ex_md_op, md_done,
    output pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_flush,
           md_start, md_abort, md_result_sel, md_error, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard compare between the load in EX and the sources of the instruction in ID.
// Purely combinational; zero latency.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  output logic       hazard_o
);

  assign hazard_o = ex_mem_read_i && (ex_rd_i != REG_X0) &&
                    (((ex_rd_i == id_rs1_i) && id_use_rs1_i) ||
                     ((ex_rd_i == id_rs2_i) && id_use_rs2_i));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: MUL/DIV freeze with watchdog > branch flush > load-use stall.
// Control outputs are Mealy (same-cycle); counters and md_error update on the rising edge.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int          TW       = $clog2(MD_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(MD_TIMEOUT - 1);

  md_state_e        state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             md_error_q, md_error_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic lu_hazard;
  logic pc_write, if_id_write, id_ex_write;
  logic if_id_flush, id_ex_flush, ex_mem_flush;
  logic md_start, md_abort, md_result_sel, branch_flush;

  load_use_detect u_lu (
    .id_rs1_i      (hz.IF_ID_rs1),
    .id_rs2_i      (hz.IF_ID_rs2),
    .id_use_rs1_i  (hz.IF_ID_use_rs1),
    .id_use_rs2_i  (hz.IF_ID_use_rs2),
    .ex_mem_read_i (hz.ID_EX_MemRead),
    .ex_rd_i       (hz.ID_EX_rd),
    .hazard_o      (lu_hazard)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      md_error_q <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      md_error_q <= md_error_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  // md_done wins over a coincident timeout.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        if (hz.ex_md_op) begin
          state_d = BUSY;
          timer_d = '0;
        end
      end
      BUSY: begin
        if (hz.md_done || (timer_q == TMO_LAST)) state_d = IDLE;
        else                                     timer_d = timer_q + TW'(1);
      end
    endcase
  end

  // Outputs are forced to their reset values while rst is high, so no abort can escape mid-reset.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    md_start      = 1'b0;
    md_abort      = 1'b0;
    md_result_sel = 1'b0;
    branch_flush  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (hz.ex_md_op) begin
            md_start     = 1'b1;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_flush = 1'b1;
          end else if (hz.ex_branch_taken) begin
            branch_flush = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
          end else if (lu_hazard) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
          end
        end
        BUSY: begin
          if (hz.md_done) begin
            md_result_sel = 1'b1;
          end else if (timer_q == TMO_LAST) begin
            md_abort = 1'b1;
          end else begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_flush = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    md_error_d = md_error_q | md_abort;
    stall_d    = pc_write     ? stall_q : CNT_W'(sat_inc(64'(stall_q), CNT_W));
    flush_d    = branch_flush ? CNT_W'(sat_inc(64'(flush_q), CNT_W)) : flush_q;
  end

  assign hz.pc_write      = pc_write;
  assign hz.if_id_write   = if_id_write;
  assign hz.id_ex_write   = id_ex_write;
  assign hz.if_id_flush   = if_id_flush;
  assign hz.id_ex_flush   = id_ex_flush;
  assign hz.ex_mem_flush  = ex_mem_flush;
  assign hz.md_start      = md_start;
  assign hz.md_abort      = md_abort;
  assign hz.md_result_sel = md_result_sel;
  assign hz.md_error      = md_error_q;
  assign hz.stall_cycles  = stall_q;
  assign hz.flush_events  = flush_q;

endmodule
